// File: rtl/defs_div_sqrt_mvp.sv
// rtl/defs_div_sqrt_mvp.sv - shared types and constants for the div_sqrt_mvp family.
package defs_div_sqrt_mvp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_sqrt_fsm_e;

  localparam int C_ITER_PER_CYCLE_MAX = 4;

  localparam int C_MANT_FP64    = 53;
  localparam int C_MANT_FP32    = 24;
  localparam int C_MANT_FP16    = 11;
  localparam int C_MANT_FP16ALT = 8;

  // ITER cycles needed for P precision bits (P+2 result bits).
  function automatic int iter_cycles(input int prec_bits, input int iter_per_cycle);
    return (prec_bits + 2 + iter_per_cycle - 1) / iter_per_cycle;
  endfunction

endpackage

// File: rtl/div_sqrt_iter_step_mvp.sv
// rtl/div_sqrt_iter_step_mvp.sv - one combinational radix-2 restoring divide/sqrt step.
module div_sqrt_iter_step_mvp #(
  parameter int RW = 58
) (
  input  logic [RW-1:0] rem_i,
  input  logic [RW-1:0] den_i,
  input  logic [1:0]    rad_i,
  input  logic          op_i,
  input  logic          en_i,
  output logic [RW-1:0] rem_o,
  output logic          q_o
);

  logic [RW-1:0] cmp;
  logic [RW-1:0] trial;
  logic [RW-1:0] diff;
  logic [RW-1:0] sel;
  logic          ge;

  // sqrt brings down two radicand bits and tries 4*root+1; divide tries the divisor
  always_comb begin
    cmp   = op_i ? {rem_i[RW-3:0], rad_i} : rem_i;
    trial = op_i ? {den_i[RW-3:0], 2'b01} : den_i;
    ge    = (cmp >= trial);
    diff  = cmp - trial;
    sel   = ge ? diff : cmp;
    q_o   = en_i & ge;
    if (!en_i) begin
      rem_o = rem_i;
    end else if (op_i) begin
      rem_o = sel;
    end else begin
      rem_o = {sel[RW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sqrt_mant_iter_mvp.sv
// rtl/div_sqrt_mant_iter_mvp.sv - iterative mantissa divide/sqrt core with
// run-time precision control and ITER_PER_CYCLE chained radix-2 steps.
module div_sqrt_mant_iter_mvp
  import defs_div_sqrt_mvp::*;
#(
  parameter int MANT_W         = 53,
  parameter int ITER_PER_CYCLE = 2,
  parameter int PC_W           = 6
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              Start_SI,
  input  logic              Kill_SI,
  input  logic              Op_SI,
  input  logic              ExpOdd_SI,
  input  logic [PC_W-1:0]   PrecCtl_SI,
  input  logic [MANT_W-1:0] MantA_DI,
  input  logic [MANT_W-1:0] MantB_DI,
  input  logic              Ready_SI,
  output logic              Busy_SO,
  output logic              Done_SO,
  output logic [MANT_W+1:0] Quot_DO,
  output logic              Sticky_SO
);

  localparam int QW    = MANT_W + 2;
  localparam int RW    = MANT_W + 5;
  localparam int SW    = 2 * QW;
  localparam int CNT_W = $clog2(QW + 1);

  div_sqrt_fsm_e state_q, state_d;
  logic             load;
  logic             last_cyc;
  logic             op_q;
  logic [CNT_W-1:0] n_q, c_q, cyc_q;
  logic [CNT_W-1:0] n_start, c_start;
  logic [RW-1:0]    rem_q, den_q;
  logic [QW-1:0]    root_q, quot_q;
  logic [SW-1:0]    rad_q, rad_start;
  logic [MANT_W:0]  x_start;
  logic             sticky_q;

  logic [RW-1:0]    rem_fin;
  logic [QW-1:0]    root_fin;
  logic [SW-1:0]    rad_fin;

  // P of 0 or above MANT_W selects full precision
  always_comb begin
    if (PrecCtl_SI == '0 || int'(PrecCtl_SI) > MANT_W) begin
      n_start = CNT_W'(QW);
    end else begin
      n_start = CNT_W'(PrecCtl_SI) + CNT_W'(2);
    end
    c_start   = CNT_W'(iter_cycles(int'(n_start) - 2, ITER_PER_CYCLE));
    x_start   = ExpOdd_SI ? {MantA_DI, 1'b0} : {1'b0, MantA_DI};
    rad_start = {x_start, {(SW - MANT_W - 1){1'b0}}};
  end

  for (genvar j = 0; j < ITER_PER_CYCLE; j++) begin : g_step
    logic [RW-1:0] rem_in, rem_out, den;
    logic [QW-1:0] root_in, root_out;
    logic [SW-1:0] rad_in, rad_out;
    logic          en, q;

    if (j == 0) begin : g_head
      assign rem_in  = rem_q;
      assign root_in = root_q;
      assign rad_in  = rad_q;
    end else begin : g_link
      assign rem_in  = g_step[j-1].rem_out;
      assign root_in = g_step[j-1].root_out;
      assign rad_in  = g_step[j-1].rad_out;
    end

    // steps past the last requested bit leave all state untouched
    assign en  = (int'(cyc_q) * ITER_PER_CYCLE + j) < int'(n_q);
    assign den = op_q ? RW'(root_in) : den_q;

    div_sqrt_iter_step_mvp #(.RW(RW)) u_step (
      .rem_i (rem_in),
      .den_i (den),
      .rad_i (rad_in[SW-1 -: 2]),
      .op_i  (op_q),
      .en_i  (en),
      .rem_o (rem_out),
      .q_o   (q)
    );

    assign root_out = en ? {root_in[QW-2:0], q} : root_in;
    assign rad_out  = en ? {rad_in[SW-3:0], 2'b00} : rad_in;
  end

  assign rem_fin  = g_step[ITER_PER_CYCLE-1].rem_out;
  assign root_fin = g_step[ITER_PER_CYCLE-1].root_out;
  assign rad_fin  = g_step[ITER_PER_CYCLE-1].rad_out;
  assign last_cyc = ((cyc_q + 1'b1) == c_q);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_SI && !Kill_SI) begin
          load    = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (Kill_SI) begin
          state_d = IDLE;
        end else if (last_cyc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (Kill_SI || Ready_SI) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      n_q      <= '0;
      c_q      <= '0;
      cyc_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      root_q   <= '0;
      rad_q    <= '0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q     <= Op_SI;
        n_q      <= n_start;
        c_q      <= c_start;
        cyc_q    <= '0;
        rem_q    <= Op_SI ? '0 : RW'(MantA_DI);
        den_q    <= RW'(MantB_DI);
        root_q   <= '0;
        rad_q    <= Op_SI ? rad_start : '0;
        quot_q   <= '0;
        sticky_q <= 1'b0;
      end else if (state_q == ITER && !Kill_SI) begin
        rem_q  <= rem_fin;
        root_q <= root_fin;
        rad_q  <= rad_fin;
        cyc_q  <= cyc_q + 1'b1;
        if (last_cyc) begin
          quot_q   <= root_fin << (CNT_W'(QW) - n_q);
          // unconsumed radicand bits also make a sqrt inexact
          sticky_q <= op_q ? ((rem_fin != '0) || (rad_fin != '0)) : (rem_fin != '0);
        end
      end
    end
  end

  assign Busy_SO   = (state_q != IDLE);
  assign Done_SO   = (state_q == DONE);
  assign Quot_DO   = quot_q;
  assign Sticky_SO = sticky_q;

  a_mant_msb : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    load |-> (MantA_DI[MANT_W-1] && (Op_SI || MantB_DI[MANT_W-1])));

endmodule

// File: tb/tb_div_sqrt_mant_iter_mvp.sv
// tb/tb_div_sqrt_mant_iter_mvp.sv - directed and randomized checks of the
// mantissa divide/sqrt core against an arbitrary-precision arithmetic model.
module tb_div_sqrt_mant_iter_mvp;
  import defs_div_sqrt_mvp::*;

  localparam int N_FINISHERS = 18;
  localparam int N_RAND      = 16;

  logic clk = 1'b0;
  logic rst_r = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_fin = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] isqrt(input logic [255:0] y);
    logic [255:0] q, t;
    q = '0;
    for (int i = 127; i >= 0; i--) begin
      t = q | (256'(1) << i);
      if (t * t <= y) q = t;
    end
    return q;
  endfunction

  function automatic int ref_n(input int mw, input int pc);
    return ((pc == 0 || pc > mw) ? mw : pc) + 2;
  endfunction

  function automatic int ref_latency(input int mw, input int pc, input int k);
    int n;
    n = ref_n(mw, pc);
    return (n + k - 1) / k + 1;
  endfunction

  // quot = floor(A/B * 2^(N-1)) or floor(sqrt(X) * 2^(N-1)), left-aligned in mw+2 bits
  task automatic ref_model(input int mw, input int pc, input logic op, input logic eo,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] quot, output logic sticky);
    int n, m, s;
    logic [255:0] num, q, r, xb, y;
    n = ref_n(mw, pc);
    if (!op) begin
      num    = 256'(a) << (n - 1);
      q      = num / 256'(b);
      r      = num % 256'(b);
      sticky = (r != '0);
    end else begin
      m      = mw - 1;
      s      = (m + 1) / 2;
      xb     = eo ? (256'(a) << 1) : 256'(a);
      y      = xb << (2 * n - 2 + 2 * s - m);
      q      = isqrt(y) >> s;
      sticky = (((q * q) << m) != (xb << (2 * n - 2)));
    end
    quot = 64'(q << (mw + 2 - n));
  endtask

  // directed instance: MANT_W=8, K=2
  logic       d_rst, d_start, d_kill, d_op, d_eo, d_ready;
  logic [5:0] d_pc;
  logic [7:0] d_a, d_b;
  logic       d_busy, d_done, d_sticky;
  logic [9:0] d_quot;

  div_sqrt_mant_iter_mvp #(.MANT_W(8), .ITER_PER_CYCLE(2), .PC_W(6)) u_dut_d (
    .Clk_CI(clk), .Rst_RI(d_rst), .Start_SI(d_start), .Kill_SI(d_kill),
    .Op_SI(d_op), .ExpOdd_SI(d_eo), .PrecCtl_SI(d_pc), .MantA_DI(d_a),
    .MantB_DI(d_b), .Ready_SI(d_ready), .Busy_SO(d_busy), .Done_SO(d_done),
    .Quot_DO(d_quot), .Sticky_SO(d_sticky)
  );

  task automatic d_launch(input logic op, input logic eo, input logic [5:0] pc,
                          input logic [7:0] a, input logic [7:0] b);
    d_op = op; d_eo = eo; d_pc = pc; d_a = a; d_b = b; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
  endtask

  task automatic d_wait_done(output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!d_done && lat < 100) begin
      if (!d_busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!d_busy) busy_ok = 1'b0;
  endtask

  task automatic d_run(input string tag, input logic op, input logic eo, input logic [5:0] pc,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [63:0] eq, input logic es, input int elat);
    int lat;
    logic busy_ok;
    d_launch(op, eo, pc, a, b);
    d_wait_done(lat, busy_ok);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_quot"}, 64'(d_quot), eq);
    check({tag, "_sticky"}, 64'(d_sticky), 64'(es));
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    check({tag, "_idle"}, 64'({d_busy, d_done}), 64'd0);
  endtask

  initial begin
    logic [63:0] eq;
    logic        es, seen;
    int          lat;
    logic        busy_ok;
    d_rst = 1'b1; d_start = 1'b0; d_kill = 1'b0; d_op = 1'b0; d_eo = 1'b0;
    d_ready = 1'b0; d_pc = '0; d_a = 8'h80; d_b = 8'h80;
    @(posedge clk); #1;
    check("rst_out", 64'({d_busy, d_done, d_sticky, d_quot}), 64'd0);
    @(posedge clk); #1;
    d_rst = 1'b0;

    d_run("div_2_3",    1'b0, 1'b0, 6'd0, 8'h80, 8'hC0, 64'h155, 1'b1, 6);
    d_run("div_ff_ff",  1'b0, 1'b0, 6'd0, 8'hFF, 8'hFF, 64'h200, 1'b0, 6);
    d_run("sqrt_1",     1'b1, 1'b0, 6'd0, 8'h80, 8'h80, 64'h200, 1'b0, 6);
    d_run("sqrt_2",     1'b1, 1'b1, 6'd0, 8'h80, 8'h80, 64'h2D4, 1'b1, 6);
    d_run("div_p4",     1'b0, 1'b0, 6'd4, 8'h80, 8'hC0, 64'h150, 1'b1, 4);
    d_run("div_p63",    1'b0, 1'b0, 6'd63, 8'h80, 8'hC0, 64'h155, 1'b1, 6);

    // kill sampled at the end of the third ITER cycle
    d_launch(1'b0, 1'b0, 6'd0, 8'h80, 8'hC0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_kill = 1'b1;
    @(posedge clk); #1;
    d_kill = 1'b0;
    check("kill_iter", 64'({d_busy, d_done}), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d_done || d_busy) seen = 1'b1;
    end
    check("kill_nodone", 64'(seen), 64'd0);

    d_start = 1'b1; d_kill = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0; d_kill = 1'b0;
    check("kill_start", 64'(d_busy), 64'd0);

    // kill while waiting in DONE
    d_launch(1'b0, 1'b0, 6'd0, 8'hA5, 8'hC3);
    d_wait_done(lat, busy_ok);
    d_kill = 1'b1;
    @(posedge clk); #1;
    d_kill = 1'b0;
    check("kill_done", 64'({d_busy, d_done}), 64'd0);

    // Done held with Ready low while Start is asserted with other operands
    ref_model(8, 0, 1'b0, 1'b0, 64'hA5, 64'hC3, eq, es);
    d_launch(1'b0, 1'b0, 6'd0, 8'hA5, 8'hC3);
    d_wait_done(lat, busy_ok);
    d_op = 1'b1; d_a = 8'hFF; d_start = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!d_done || d_quot !== eq[9:0] || d_sticky !== es) seen = 1'b1;
    end
    check("hold_stable", 64'(seen), 64'd0);
    check("hold_quot", 64'(d_quot), eq);
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0; d_start = 1'b0;
    check("ready_start", 64'(d_busy), 64'd0);
    check("idle_hold", 64'(d_quot), eq);

    // synchronous reset in the middle of an operation
    d_launch(1'b1, 1'b1, 6'd0, 8'hC7, 8'h80);
    @(posedge clk); #1;
    d_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", 64'({d_busy, d_done, d_sticky, d_quot}), 64'd0);
    d_rst = 1'b0;

    ref_model(8, 3, 1'b1, 1'b1, 64'hC7, 64'h80, eq, es);
    d_run("after_rst", 1'b1, 1'b1, 6'd3, 8'hC7, 8'h80, eq, es, ref_latency(8, 3, 2));
    n_fin++;
  end

  // K=4 instance for the reduced-precision latency case
  logic       e_start, e_ready, e_busy, e_done, e_sticky;
  logic [9:0] e_quot;

  div_sqrt_mant_iter_mvp #(.MANT_W(8), .ITER_PER_CYCLE(4), .PC_W(6)) u_dut_e (
    .Clk_CI(clk), .Rst_RI(rst_r), .Start_SI(e_start), .Kill_SI(1'b0),
    .Op_SI(1'b0), .ExpOdd_SI(1'b0), .PrecCtl_SI(6'd4), .MantA_DI(8'h80),
    .MantB_DI(8'hC0), .Ready_SI(e_ready), .Busy_SO(e_busy), .Done_SO(e_done),
    .Quot_DO(e_quot), .Sticky_SO(e_sticky)
  );

  initial begin
    int lat;
    e_start = 1'b0; e_ready = 1'b0;
    wait (rst_r == 1'b0);
    @(posedge clk); #1;
    e_start = 1'b1;
    @(posedge clk); #1;
    e_start = 1'b0;
    lat = 1;
    while (!e_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("k4_lat", 64'(lat), 64'd3);
    check("k4_quot", 64'(e_quot), 64'h150);
    check("k4_sticky", 64'(e_sticky), 64'd1);
    n_fin++;
  end

  // randomized regression over all formats and K = 1..4
  for (genvar fi = 0; fi < 4; fi++) begin : g_fmt
    for (genvar ki = 1; ki <= 4; ki++) begin : g_k
      localparam int MW = (fi == 0) ? C_MANT_FP64 : (fi == 1) ? C_MANT_FP32 :
                          (fi == 2) ? C_MANT_FP16 : C_MANT_FP16ALT;

      logic          r_start, r_op, r_eo, r_ready, r_busy, r_done, r_sticky;
      logic [5:0]    r_pc;
      logic [MW-1:0] r_a, r_b;
      logic [MW+1:0] r_quot;

      div_sqrt_mant_iter_mvp #(.MANT_W(MW), .ITER_PER_CYCLE(ki), .PC_W(6)) u_dut (
        .Clk_CI(clk), .Rst_RI(rst_r), .Start_SI(r_start), .Kill_SI(1'b0),
        .Op_SI(r_op), .ExpOdd_SI(r_eo), .PrecCtl_SI(r_pc), .MantA_DI(r_a),
        .MantB_DI(r_b), .Ready_SI(r_ready), .Busy_SO(r_busy), .Done_SO(r_done),
        .Quot_DO(r_quot), .Sticky_SO(r_sticky)
      );

      initial begin
        logic [63:0] tmp, eq;
        logic        es;
        int          lat;
        string       tag;
        r_start = 1'b0; r_op = 1'b0; r_eo = 1'b0; r_ready = 1'b0;
        r_pc = '0; r_a = '0; r_b = '0;
        tag = $sformatf("rnd_m%0d_k%0d", MW, ki);
        wait (rst_r == 1'b0);
        @(posedge clk); #1;
        for (int t = 0; t < N_RAND; t++) begin
          tmp = {$urandom(), $urandom()};
          if (t == 0) tmp = '0;
          if (t == 1) tmp = '1;
          tmp[MW-1] = 1'b1;
          r_a = tmp[MW-1:0];
          tmp = {$urandom(), $urandom()};
          if (t == 1) tmp = '1;
          tmp[MW-1] = 1'b1;
          r_b = tmp[MW-1:0];
          r_pc = 6'($urandom_range(0, 63));
          r_op = 1'($urandom_range(0, 1));
          r_eo = 1'($urandom_range(0, 1));
          ref_model(MW, int'(r_pc), r_op, r_eo, 64'(r_a), 64'(r_b), eq, es);
          r_start = 1'b1;
          @(posedge clk); #1;
          r_start = 1'b0;
          lat = 1;
          while (!r_done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
          end
          check({tag, "_lat"}, 64'(lat), 64'(ref_latency(MW, int'(r_pc), ki)));
          check({tag, "_quot"}, 64'(r_quot), eq);
          check({tag, "_sticky"}, 64'(r_sticky), 64'(es));
          r_ready = 1'b1;
          @(posedge clk); #1;
          r_ready = 1'b0;
        end
        n_fin++;
      end
    end
  end

  initial begin
    int cyc;
    rst_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_r = 1'b0;
    cyc = 0;
    while (n_fin < N_FINISHERS && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    check("finish_count", 64'(n_fin), 64'(N_FINISHERS));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
